// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulate path: controller states and width helper.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full operand width for a word-serial datapath of n slices of p bits.
  function automatic int word_width(input int p, input int n);
    return p * n;
  endfunction

endpackage

// File: rtl/Full_Adder_P_bit.sv
// P-bit ripple-carry adder slice; the only arithmetic in the word-serial datapath.
module Full_Adder_P_bit #(
  parameter int P = 4
) (
  input  logic [P-1:0] a,
  input  logic [P-1:0] b,
  input  logic         cin,
  output logic [P-1:0] s,
  output logic         cout
);

  logic [P:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < P; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[P];

endmodule

// File: rtl/word_serial_adder_ctrl.sv
// Word-serial add/subtract: one P-bit slice per cycle, LSW first, carry chained
// through a register; valid/ready on both sides, no overlap between operations.
module word_serial_adder_ctrl
  import mac_pkg::*;
#(
  parameter  int P       = 4,
  parameter  int N_WORDS = 4,
  localparam int W       = word_width(P, N_WORDS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int             IW   = $clog2(N_WORDS);
  localparam logic [IW-1:0]  LAST = IW'(N_WORDS - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh, b_sh;
  logic          carry;
  logic          a_msb, b_msb;
  logic [IW-1:0] idx;
  logic [P-1:0]  s_slice;
  logic          c_slice;
  logic          accept, last;

  assign accept    = (state == IDLE) && in_valid && !clr;
  assign last      = (state == RUN) && (idx == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  Full_Adder_P_bit #(.P(P)) u_slice (
    .a    (a_sh[P-1:0]),
    .b    (b_sh[P-1:0]),
    .cin  (carry),
    .s    (s_slice),
    .cout (c_slice)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = RUN;
      RUN:     if (idx == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Operands are consumed from the bottom; the result is shifted in from the top
  // so after N_WORDS slices it lands word-aligned in sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub;
      a_msb <= a[W-1];
      b_msb <= sub ? ~b[W-1] : b[W-1];
      idx   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> P;
      b_sh  <= b_sh >> P;
      carry <= c_slice;
      sum   <= {s_slice, sum[W-1:P]};
      if (last) begin
        idx  <= '0;
        cout <= c_slice;
        ovf  <= (a_msb == b_msb) && (s_slice[P-1] != a_msb);
      end else begin
        idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_serial_adder_ctrl.sv
// Self-checking bench: arithmetic reference model checked every cycle plus literal cases.
module tb_word_serial_adder_ctrl;

  localparam int P = 4;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  int           m_busy = 0;
  bit           m_done = 0;
  logic [W-1:0] m_sum = '0;
  bit           m_cout = 0;
  bit           m_ovf = 0;

  word_serial_adder_ctrl #(.P(P), .N_WORDS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: {ovf, cout, sum}
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    int sx, sy, r;
    logic [W-1:0] rs;
    bit rc, ro;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = s ? sx - sy : sx + sy;
    ro = (r > 32767) || (r < -32768);
    rs = s ? x - y : x + y;
    rc = s ? (x >= y) : ((int'(x) + int'(y)) > 65535);
    return {ro, rc, rs};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_done <= 0;
    end else if (clr) begin
      m_busy <= 0;
      m_done <= 0;
    end else if (m_done) begin
      if (out_ready) m_done <= 0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_done <= 1;
    end else if (in_valid) begin
      {m_ovf, m_cout, m_sum} <= ref_op(a, b, sub);
      m_busy <= N;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, (m_busy == 0) && !m_done);
      chk("out_valid", out_valid, m_done);
      if (m_done && out_valid) begin
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
        chk("ovf", ovf, m_ovf);
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit ts);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  task automatic finish_out(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic op_lit(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit ts,
                        input logic [W-1:0] es, input bit ec, input bit eo);
    int lat;
    send(ta, tb, ts);
    wait_valid(lat);
    chk("latency", lat, N);
    chk("lit_sum", sum, es);
    chk("lit_cout", cout, ec);
    chk("lit_ovf", ovf, eo);
    finish_out(0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] corner [4];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    started = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);

    op_lit(16'h00FF, 16'h0001, 0, 16'h0100, 0, 0);
    op_lit(16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    op_lit(16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    op_lit(16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);
    op_lit(16'h0003, 16'h0005, 1, 16'hFFFE, 0, 0);

    // Backpressure with a competing request during DONE
    send(16'h1234, 16'h0F0F, 0);
    wait_valid(lat);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_sum", sum, 16'h2143);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after", in_ready, 1);
    a = 16'h0002; b = 16'h0003; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_next_sum", sum, 16'h0005);
    finish_out(0);

    // clr on the second RUN cycle
    send(16'hFFFF, 16'h0001, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_idle", in_ready, 1);
    chk("clr_no_valid", out_valid, 0);
    repeat (6) @(negedge clk);
    op_lit(16'h1234, 16'h1111, 0, 16'h2345, 0, 0);

    // clr together with in_valid in IDLE: nothing captured
    a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    chk("clr_idle_capture", in_ready, 1);
    repeat (5) @(negedge clk);

    // Asynchronous reset between edges mid-RUN
    send(16'h0F0F, 16'h0101, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_lit(16'h0F0F, 16'h0101, 0, 16'h1010, 0, 0);

    // Randomized traffic, checked by the model every cycle
    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] ta, tb;
      ta = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      tb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      send(ta, tb, 1'($urandom_range(0, 1)));
      wait_valid(lat);
      finish_out($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
